wb_interconnect_1xn: RTL and testbench

//  Single-master to N-slave Wishbone B4 interconnect with N_SLAVES, widths and the address map set by parameters.

---
 rtl/wb_ic_pkg.sv | 18 +
 rtl/wb_ic_addr_decode.sv | 30 +++
 rtl/wb_interconnect_1xn.sv | 164 ++++++++++++++++
 tb/tb_wb_interconnect_1xn.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_ic_pkg.sv
// Shared types and helpers for the 1xN Wishbone interconnect.
// Optional watchdog in the top is enabled by defining WB_IC_TIMEOUT_EN.
package wb_ic_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACTIVE,
      DEFERR
   } ic_state_e;

   function automatic int unsigned sel_bits(input int unsigned n);
      return $clog2(n + 1);
   endfunction

   // Wide enough for 16 slaves; callers slice down to sel_bits(N).
   localparam logic [4:0] NO_SLAVE = '1;

endpackage

// File: rtl/wb_ic_addr_decode.sv
// Combinational address range compare with lowest-index-wins priority.
// Range table is packed {base0,limit0,base1,limit1,...}, slave 0 most significant.
module wb_ic_addr_decode
   import wb_ic_pkg::*;
#(
   parameter int unsigned                   AW          = 32,
   parameter int unsigned                   N           = 6,
   parameter logic [2*N*AW-1:0]             ADDR_RANGES = '0
) (
   input  logic [AW-1:0]          i_adr,
   output logic                   o_hit,
   output logic [sel_bits(N)-1:0] o_idx
);

   localparam int unsigned SW = sel_bits(N);

   always_comb begin
      o_hit = 1'b0;
      o_idx = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (!o_hit &&
             (i_adr >= ADDR_RANGES[(2*(N-1-i)+1)*AW +: AW]) &&
             (i_adr <= ADDR_RANGES[(2*(N-1-i))*AW +: AW])) begin
            o_hit = 1'b1;
            o_idx = SW'(i);
         end
      end
   end

endmodule

// File: rtl/wb_interconnect_1xn.sv
// Single-master to N-slave Wishbone B4 interconnect, registered decode, grant locked per CYC.
// Define WB_IC_TIMEOUT_EN to add a stall watchdog that forces ERR after TIMEOUT_CYCLES.
module wb_interconnect_1xn
   import wb_ic_pkg::*;
#(
   parameter int unsigned                          WB_ADDR_WIDTH  = 32,
   parameter int unsigned                          WB_DATA_WIDTH  = 32,
   parameter int unsigned                          N_SLAVES       = 6,
   parameter logic [2*N_SLAVES*WB_ADDR_WIDTH-1:0]  ADDR_RANGES    = '0,
   parameter int unsigned                          TIMEOUT_CYCLES = 256
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic [WB_ADDR_WIDTH-1:0]                  m_adr,
   input  logic [WB_DATA_WIDTH-1:0]                  m_dat_w,
   input  logic [WB_DATA_WIDTH/8-1:0]                m_sel,
   input  logic [2:0]                                m_cti,
   input  logic [1:0]                                m_bte,
   input  logic                                      m_cyc,
   input  logic                                      m_stb,
   input  logic                                      m_we,
   output logic [WB_DATA_WIDTH-1:0]                  m_dat_r,
   output logic                                      m_ack,
   output logic                                      m_err,
   output logic [N_SLAVES*WB_ADDR_WIDTH-1:0]         s_adr,
   output logic [N_SLAVES*WB_DATA_WIDTH-1:0]         s_dat_w,
   output logic [N_SLAVES*WB_DATA_WIDTH/8-1:0]       s_sel,
   output logic [N_SLAVES*3-1:0]                     s_cti,
   output logic [N_SLAVES*2-1:0]                     s_bte,
   output logic [N_SLAVES-1:0]                       s_we,
   output logic [N_SLAVES-1:0]                       s_cyc,
   output logic [N_SLAVES-1:0]                       s_stb,
   input  logic [N_SLAVES*WB_DATA_WIDTH-1:0]         s_dat_r,
   input  logic [N_SLAVES-1:0]                       s_ack,
   input  logic [N_SLAVES-1:0]                       s_err
);

   localparam int unsigned AW = WB_ADDR_WIDTH;
   localparam int unsigned DW = WB_DATA_WIDTH;
   localparam int unsigned SW = sel_bits(N_SLAVES);
   localparam logic [SW-1:0] NO_SEL = NO_SLAVE[SW-1:0];

   if (N_SLAVES < 1 || N_SLAVES > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("wb_interconnect_1xn: illegal parameter set");
   end

   ic_state_e       r_state, w_state_nxt;
   logic [SW-1:0]   r_sel, w_sel_nxt;
   logic            r_err, w_err_nxt;
   logic            w_hit;
   logic [SW-1:0]   w_idx;
   logic            w_slv_ack, w_slv_err;
   logic [DW-1:0]   w_slv_dat;
   logic            w_timeout;

   wb_ic_addr_decode #(
      .AW          (AW),
      .N           (N_SLAVES),
      .ADDR_RANGES (ADDR_RANGES)
   ) u_decode (
      .i_adr (m_adr),
      .o_hit (w_hit),
      .o_idx (w_idx)
   );

   assign s_adr   = {N_SLAVES{m_adr}};
   assign s_dat_w = {N_SLAVES{m_dat_w}};
   assign s_sel   = {N_SLAVES{m_sel}};
   assign s_cti   = {N_SLAVES{m_cti}};
   assign s_bte   = {N_SLAVES{m_bte}};
   assign s_we    = {N_SLAVES{m_we}};

   always_comb begin
      w_slv_ack = 1'b0;
      w_slv_err = 1'b0;
      w_slv_dat = '0;
      for (int unsigned i = 0; i < N_SLAVES; i++) begin
         if (r_sel == SW'(i)) begin
            w_slv_ack = s_ack[i];
            w_slv_err = s_err[i];
            w_slv_dat = s_dat_r[i*DW +: DW];
         end
      end
   end

`ifdef WB_IC_TIMEOUT_EN
   localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES + 1);
   logic [WDW-1:0] r_wdog;

   assign w_timeout = (r_wdog == WDW'(TIMEOUT_CYCLES));

   // Held at zero outside ACTIVE, so every entry into ACTIVE starts a fresh count.
   always_ff @(posedge clk) begin
      if (rst || r_state != ACTIVE || w_slv_ack || w_slv_err) begin
         r_wdog <= '0;
      end else if (m_stb && !w_timeout) begin
         r_wdog <= r_wdog + 1'b1;
      end
   end
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_sel   <= NO_SEL;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_sel   <= w_sel_nxt;
         r_err   <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_sel_nxt   = r_sel;
      w_err_nxt   = 1'b0;
      s_cyc       = '0;
      s_stb       = '0;
      m_ack       = 1'b0;
      m_err       = 1'b0;
      m_dat_r     = '0;
      unique case (r_state)
         IDLE: begin
            if (m_cyc && m_stb) begin
               w_sel_nxt   = w_hit ? w_idx : NO_SEL;
               w_state_nxt = w_hit ? ACTIVE : DEFERR;
            end
         end
         ACTIVE: begin
            if (!m_cyc || w_timeout) begin
               w_state_nxt = m_cyc ? DEFERR : IDLE;
               w_sel_nxt   = NO_SEL;
            end else begin
               for (int unsigned i = 0; i < N_SLAVES; i++) begin
                  if (r_sel == SW'(i)) begin
                     s_cyc[i] = m_cyc;
                     s_stb[i] = m_stb;
                  end
               end
               m_ack   = w_slv_ack;
               m_err   = w_slv_err;
               m_dat_r = w_slv_dat;
            end
         end
         DEFERR: begin
            m_err = r_err;
            if (!m_cyc) begin
               w_state_nxt = IDLE;
               w_sel_nxt   = NO_SEL;
            end else begin
               w_err_nxt = m_stb & ~r_err;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_sel_nxt   = NO_SEL;
         end
      endcase
   end

endmodule

// File: tb/tb_wb_interconnect_1xn.sv
// Directed bench for wb_interconnect_1xn (N=2); covers WB_IC_TIMEOUT_EN when defined.
module tb_wb_interconnect_1xn;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] m_adr;
   logic [31:0] m_dat_w;
   logic [3:0]  m_sel;
   logic [2:0]  m_cti;
   logic [1:0]  m_bte;
   logic        m_cyc, m_stb, m_we;
   logic [31:0] m_dat_r;
   logic        m_ack, m_err;
   logic [63:0] s_adr, s_dat_w;
   logic [7:0]  s_sel;
   logic [5:0]  s_cti;
   logic [3:0]  s_bte;
   logic [1:0]  s_we, s_cyc, s_stb;
   logic [63:0] s_dat_r;
   logic [1:0]  s_ack, s_err;

   logic [31:0] o_m_dat_r;
   logic        o_m_ack, o_m_err;
   logic [63:0] o_s_adr, o_s_dat_w;
   logic [7:0]  o_s_sel;
   logic [5:0]  o_s_cti;
   logic [3:0]  o_s_bte;
   logic [1:0]  o_s_we, o_s_cyc, o_s_stb;
   logic [63:0] o_s_dat_r = '0;
   logic [1:0]  o_s_ack = '0, o_s_err = '0;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   wb_interconnect_1xn #(
      .WB_ADDR_WIDTH  (32),
      .WB_DATA_WIDTH  (32),
      .N_SLAVES       (2),
      .ADDR_RANGES    ({32'h0000_0000, 32'h0000_0FFF, 32'h0000_1000, 32'h0000_1FFF}),
      .TIMEOUT_CYCLES (8)
   ) u_dut (
      .clk(clk), .rst(rst), .m_adr(m_adr), .m_dat_w(m_dat_w), .m_sel(m_sel),
      .m_cti(m_cti), .m_bte(m_bte), .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
      .m_dat_r(m_dat_r), .m_ack(m_ack), .m_err(m_err),
      .s_adr(s_adr), .s_dat_w(s_dat_w), .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte),
      .s_we(s_we), .s_cyc(s_cyc), .s_stb(s_stb),
      .s_dat_r(s_dat_r), .s_ack(s_ack), .s_err(s_err)
   );

   wb_interconnect_1xn #(
      .WB_ADDR_WIDTH  (32),
      .WB_DATA_WIDTH  (32),
      .N_SLAVES       (2),
      .ADDR_RANGES    ({32'h0000_0000, 32'h0000_00FF, 32'h0000_0080, 32'h0000_01FF}),
      .TIMEOUT_CYCLES (8)
   ) u_ovl (
      .clk(clk), .rst(rst), .m_adr(m_adr), .m_dat_w(m_dat_w), .m_sel(m_sel),
      .m_cti(m_cti), .m_bte(m_bte), .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
      .m_dat_r(o_m_dat_r), .m_ack(o_m_ack), .m_err(o_m_err),
      .s_adr(o_s_adr), .s_dat_w(o_s_dat_w), .s_sel(o_s_sel), .s_cti(o_s_cti), .s_bte(o_s_bte),
      .s_we(o_s_we), .s_cyc(o_s_cyc), .s_stb(o_s_stb),
      .s_dat_r(o_s_dat_r), .s_ack(o_s_ack), .s_err(o_s_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_bus();
      m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0; m_cti = 3'b000;
      s_ack = '0;   s_err = '0;
   endtask

   initial begin
      rst = 1'b1;
      m_adr = '0; m_dat_w = '0; m_sel = 4'hF; m_bte = 2'b00;
      s_dat_r = '0;
      idle_bus();
      tick(); tick();
      rst = 1'b0;
      #1;
      chk("rst_s_cyc", 64'(s_cyc), 64'h0);
      chk("rst_s_stb", 64'(s_stb), 64'h0);
      chk("rst_m_ack", 64'(m_ack), 64'h0);
      chk("rst_m_err", 64'(m_err), 64'h0);
      chk("rst_m_dat_r", 64'(m_dat_r), 64'h0);

      // read 0x1004 -> slave 1 after one decode cycle
      m_adr = 32'h0000_1004; m_sel = 4'hA; m_cyc = 1'b1; m_stb = 1'b1;
      s_dat_r = {32'hCAFE_0001, 32'h1111_2222};
      #1;
      chk("rd_decode_s_cyc", 64'(s_cyc), 64'h0);
      chk("rd_bcast_adr", s_adr, 64'h0000_1004_0000_1004);
      chk("rd_bcast_sel", 64'(s_sel), 64'hAA);
      tick();
      chk("rd_active_s_cyc", 64'(s_cyc), 64'h2);
      chk("rd_active_s_stb", 64'(s_stb), 64'h2);
      chk("rd_wait_m_ack", 64'(m_ack), 64'h0);
      s_ack = 2'b10;
      #1;
      chk("rd_m_ack", 64'(m_ack), 64'h1);
      chk("rd_m_dat_r", 64'(m_dat_r), 64'hCAFE_0001);
      tick();
      idle_bus();
      #1;
      chk("rd_drop_s_cyc", 64'(s_cyc), 64'h0);
      tick();
      chk("rd_idle_m_dat_r", 64'(m_dat_r), 64'h0);

      // write to unmapped 0x2000 -> default slave ERR, one pulse per beat
      m_adr = 32'h0000_2000; m_we = 1'b1; m_cyc = 1'b1; m_stb = 1'b1;
      tick();
      chk("unm_s_cyc", 64'(s_cyc), 64'h0);
      chk("unm_err_wait", 64'(m_err), 64'h0);
      tick();
      chk("unm_err_pulse", 64'(m_err), 64'h1);
      chk("unm_ack", 64'(m_ack), 64'h0);
      chk("unm_dat_r", 64'(m_dat_r), 64'h0);
      tick();
      chk("unm_err_low", 64'(m_err), 64'h0);
      chk("unm_s_cyc2", 64'(s_cyc), 64'h0);
      idle_bus();
      tick();

      // 4-beat incrementing burst from 0x0FFC stays on slave 0
      m_adr = 32'h0000_0FFC; m_cti = 3'b010; m_cyc = 1'b1; m_stb = 1'b1;
      tick();
      s_ack = 2'b01;
      for (int k = 0; k < 4; k++) begin
         m_adr = 32'h0000_0FFC + 32'(4 * k);
         if (k == 3) m_cti = 3'b111;
         s_dat_r = {32'hDEAD_BEEF, 32'hB000_0000 + 32'(k)};
         #1;
         chk("bst_s_cyc", 64'(s_cyc), 64'h1);
         chk("bst_m_ack", 64'(m_ack), 64'h1);
         chk("bst_m_dat_r", 64'(m_dat_r), 64'hB000_0000 + 64'(k));
         tick();
      end
      idle_bus();
      tick();

      // overlapping ranges: lowest index wins
      m_adr = 32'h0000_0090; m_cyc = 1'b1; m_stb = 1'b1;
      tick();
      chk("ovl_s_cyc", 64'(o_s_cyc), 64'h1);
      idle_bus();
      tick();

      // reset mid-burst with slave 0 acking
      m_adr = 32'h0000_0100; m_cti = 3'b010; m_cyc = 1'b1; m_stb = 1'b1;
      tick();
      chk("rstm_pre_s_cyc", 64'(s_cyc), 64'h1);
      s_ack = 2'b01;
      rst = 1'b1;
      tick();
      chk("rstm_s_cyc", 64'(s_cyc), 64'h0);
      chk("rstm_m_ack", 64'(m_ack), 64'h0);
      chk("rstm_m_dat_r", 64'(m_dat_r), 64'h0);
      rst = 1'b0;
      idle_bus();
      tick();
      m_adr = 32'h0000_1008; m_cyc = 1'b1; m_stb = 1'b1;
      tick();
      chk("post_rst_redecode", 64'(s_cyc), 64'h2);
      idle_bus();
      tick();

      // slave 0 never acks
      m_adr = 32'h0000_0010; m_cyc = 1'b1; m_stb = 1'b1;
      tick();
      chk("stall_start_s_cyc", 64'(s_cyc), 64'h1);
`ifdef WB_IC_TIMEOUT_EN
      for (int k = 1; k < 8; k++) begin
         tick();
         chk("to_stall_s_cyc", 64'(s_cyc), 64'h1);
      end
      tick();
      chk("to_drop_s_cyc", 64'(s_cyc), 64'h0);
      chk("to_drop_m_err", 64'(m_err), 64'h0);
      tick();
      chk("to_deferr_wait", 64'(m_err), 64'h0);
      tick();
      chk("to_m_err", 64'(m_err), 64'h1);
      idle_bus();
      tick();
      chk("to_idle_m_err", 64'(m_err), 64'h0);
      chk("to_idle_s_cyc", 64'(s_cyc), 64'h0);
`else
      for (int k = 1; k < 20; k++) tick();
      chk("stall_held_s_cyc", 64'(s_cyc), 64'h1);
      chk("stall_no_err", 64'(m_err), 64'h0);
      idle_bus();
      #1;
      chk("stall_release_s_cyc", 64'(s_cyc), 64'h0);
      tick();
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
